ps2_key_event_fifo: RTL

Parametrised scan-code processor between the PS/2 byte receiver (ps2_keyboard) and downstream consumers (ASCII lookup RAMs, HEX display, text console).
- Pops bytes from the receiver with its active-low next-data handshake.
- Parses set-2 prefixes (E0, F0, E1) into make/break events with an extended flag.
- Tracks left/right modifiers and caps lock.
- Buffers events in a show-ahead FIFO with valid/ready output handshake.
- Keeps a wrapping key-press counter.

---
 rtl/ps2_key_event_fifo.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_event_fifo.sv
// PS/2 set-2 scan-code parser with modifier tracking, a show-ahead event FIFO
// and a wrapping key-press counter.
// Optional build macro KEY_REPEAT_FILTER_EN: when defined, typematic repeats
// of the most recently pressed key are suppressed until that key is released.
module ps2_key_event_fifo #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned E1_SKIP    = 7
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_ready,
    output logic                          rx_next_n,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic [3:0]                    evt_mods,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [CNT_W-1:0]              press_count,
    output logic                          shift,
    output logic                          ctrl,
    output logic                          alt,
    output logic                          caps,
    output logic                          upper
);

    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned SKW = $clog2(E1_SKIP + 2);

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [3:0] mods;
    } evt_t;

    typedef enum logic [2:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0, ST_SKIP} state_t;

    state_t           state_q, state_d;
    logic [SKW-1:0]   skip_q, skip_d;
    logic             rx_next_n_q;
    logic             accept;
    logic             emit_c, ext_c, brk_c, fire;
    logic             fake_shift, discard;

    logic lshift_q, rshift_q, lctrl_q, rctrl_q, lalt_q, ralt_q, caps_q, caps_held_q;
    logic lshift_d, rshift_d, lctrl_d, rctrl_d, lalt_d, ralt_d, caps_d, caps_held_d;
    logic [3:0]       mods_q, mods_d;
    logic             upper_q;
    logic [CNT_W-1:0] press_q;

    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             overflow_q;
    logic             full, valid, push, pop;
    evt_t             mem_q [FIFO_DEPTH];
    evt_t             wr_evt, head;

    assign accept     = rx_ready & rx_next_n_q;
    assign fake_shift = (rx_data == 8'h12) || (rx_data == 8'h59);
    assign discard    = (rx_data == 8'h00) || (rx_data == 8'hAA) || (rx_data == 8'hEE) ||
                        (rx_data == 8'hFA) || (rx_data == 8'hFE) || (rx_data == 8'hFF);

    // Receiver handshake: pulse next-data low the cycle after a byte is taken
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) rx_next_n_q <= 1'b1;
        else       rx_next_n_q <= ~accept;
    end

    // Parser state register and E1 skip counter
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    // Parser next-state
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_data == 8'hE0)      state_d = ST_E0;
                    else if (rx_data == 8'hF0) state_d = ST_F0;
                    else if (rx_data == 8'hE1) begin
                        skip_d  = SKW'(E1_SKIP);
                        state_d = (E1_SKIP == 0) ? ST_IDLE : ST_SKIP;
                    end
                end
                ST_E0:   state_d = (rx_data == 8'hF0) ? ST_E0F0 : ST_IDLE;
                ST_F0,
                ST_E0F0: state_d = ST_IDLE;
                ST_SKIP: begin
                    skip_d = skip_q - SKW'(1);
                    if (skip_q <= SKW'(1)) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Parser outputs: which accepted bytes complete an event
    always_comb begin
        emit_c = 1'b0;
        ext_c  = 1'b0;
        brk_c  = 1'b0;
        if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_data == 8'hE1) begin
                        emit_c = 1'b1;
                        ext_c  = 1'b1;
                    end else if (!(rx_data == 8'hE0 || rx_data == 8'hF0 || discard)) begin
                        emit_c = 1'b1;
                    end
                end
                ST_E0: begin
                    if (!(rx_data == 8'hF0 || fake_shift)) begin
                        emit_c = 1'b1;
                        ext_c  = 1'b1;
                    end
                end
                ST_F0: begin
                    emit_c = 1'b1;
                    brk_c  = 1'b1;
                end
                ST_E0F0: begin
                    if (!fake_shift) begin
                        emit_c = 1'b1;
                        ext_c  = 1'b1;
                        brk_c  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef KEY_REPEAT_FILTER_EN
    logic [7:0] last_code_q;
    logic       last_ext_q, last_held_q, same_c;

    assign same_c = last_held_q && (rx_data == last_code_q) && (ext_c == last_ext_q);
    assign fire   = emit_c & ~(~brk_c & same_c);

    // Remember the held key so its typematic makes can be dropped
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            last_code_q <= '0;
            last_ext_q  <= 1'b0;
            last_held_q <= 1'b0;
        end else if (fire) begin
            if (brk_c) begin
                if (same_c) last_held_q <= 1'b0;
            end else begin
                last_code_q <= rx_data;
                last_ext_q  <= ext_c;
                last_held_q <= 1'b1;
            end
        end
    end
`else
    assign fire = emit_c;
`endif

    // Modifier next-state from the event being emitted this cycle
    always_comb begin
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        lctrl_d     = lctrl_q;
        rctrl_d     = rctrl_q;
        lalt_d      = lalt_q;
        ralt_d      = ralt_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        if (fire) begin
            if (!ext_c) begin
                unique case (rx_data)
                    8'h12: lshift_d = ~brk_c;
                    8'h59: rshift_d = ~brk_c;
                    8'h14: lctrl_d  = ~brk_c;
                    8'h11: lalt_d   = ~brk_c;
                    8'h58: begin
                        if (!brk_c && !caps_held_q) caps_d = ~caps_q;
                        caps_held_d = ~brk_c;
                    end
                    default: ;
                endcase
            end else begin
                unique case (rx_data)
                    8'h14: rctrl_d = ~brk_c;
                    8'h11: ralt_d  = ~brk_c;
                    default: ;
                endcase
            end
        end
        mods_d = {caps_d, lalt_d | ralt_d, lctrl_d | rctrl_d, lshift_d | rshift_d};
    end

    // Modifier flags, live summary and press counter
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            lctrl_q     <= 1'b0;
            rctrl_q     <= 1'b0;
            lalt_q      <= 1'b0;
            ralt_q      <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            mods_q      <= '0;
            upper_q     <= 1'b0;
            press_q     <= '0;
        end else begin
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            lctrl_q     <= lctrl_d;
            rctrl_q     <= rctrl_d;
            lalt_q      <= lalt_d;
            ralt_q      <= ralt_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            mods_q      <= mods_d;
            upper_q     <= mods_d[3] ^ mods_d[0];
            if (fire && !brk_c) press_q <= press_q + CNT_W'(1);
        end
    end

    assign full   = (cnt_q == CW'(FIFO_DEPTH));
    assign valid  = (cnt_q != '0);
    assign pop    = valid & evt_ready;
    assign push   = fire & (~full | pop);
    assign wr_evt = '{code: rx_data, ext: ext_c, brk: brk_c, mods: mods_d};
    assign head   = mem_q[rd_q];

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
            if (fire && full && !pop) overflow_q <= 1'b1;
        end
    end

    // FIFO storage; contents are only observed while valid
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= wr_evt;
    end

    assign rx_next_n   = rx_next_n_q;
    assign evt_valid   = valid;
    assign evt_code    = valid ? head.code : 8'h00;
    assign evt_ext     = valid & head.ext;
    assign evt_break   = valid & head.brk;
    assign evt_mods    = valid ? head.mods : 4'h0;
    assign fifo_count  = cnt_q;
    assign overflow    = overflow_q;
    assign press_count = press_q;
    assign shift       = mods_q[0];
    assign ctrl        = mods_q[1];
    assign alt         = mods_q[2];
    assign caps        = mods_q[3];
    assign upper       = upper_q;

endmodule
